// File: rtl/keypad_scanner.sv
// keypad_scanner: scans a 4x4 active-low matrix keypad one column at a time,
// debounces press and release, and reports each accepted press as a one-cycle
// key_valid pulse with the hex code of the key.
//
// Optional feature macro: KEYPAD_HISTORY_EN adds a two-digit key history
// (digit_new / digit_old) for the seven-segment display path.
//
// Parameters:
//   SCAN_DIV        clk cycles per scan tick (column dwell), >= 4
//   DEBOUNCE_TICKS  consecutive stable ticks to accept a press/release, >= 1
// Ports:
//   clk        system clock
//   reset      asynchronous active-high reset
//   row        keypad rows, active-low, asynchronous to clk
//   col        keypad columns, active-low, exactly one bit low
//   key        hex code of the last accepted key
//   key_valid  one-cycle pulse when a press is accepted
//   key_held   high from press acceptance until release acceptance
//   digit_new  most recent key (KEYPAD_HISTORY_EN only)
//   digit_old  previous key    (KEYPAD_HISTORY_EN only)
module keypad_scanner #(
  parameter int unsigned SCAN_DIV       = 256,
  parameter int unsigned DEBOUNCE_TICKS = 10
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [3:0] row,
  output logic [3:0] col,
  output logic [3:0] key,
  output logic       key_valid,
  output logic       key_held
`ifdef KEYPAD_HISTORY_EN
  ,
  output logic [3:0] digit_new,
  output logic [3:0] digit_old
`endif
);

  localparam int unsigned PW = $clog2(SCAN_DIV);
  localparam int unsigned DW = $clog2(DEBOUNCE_TICKS + 1);

  typedef enum logic [1:0] {
    SCAN     = 2'd0,
    PRESS_DB = 2'd1,
    HELD     = 2'd2,
    REL_DB   = 2'd3
  } state_t;

  state_t        state;
  logic [3:0]    row_m;
  logic [3:0]    row_s;
  logic [PW-1:0] presc;
  logic          tick;
  logic [1:0]    col_idx;
  logic [1:0]    row_idx;
  logic [DW-1:0] dbc;
  logic          db_done;

  // Active-low one-hot column drive for a column index.
  function automatic logic [3:0] col_drive(input logic [1:0] idx);
    col_drive = ~(4'b0001 << idx);
  endfunction

  // Lowest-numbered low row; simultaneous presses resolve to the lowest row.
  function automatic logic [1:0] first_low(input logic [3:0] rs);
    if (!rs[0])      first_low = 2'd0;
    else if (!rs[1]) first_low = 2'd1;
    else if (!rs[2]) first_low = 2'd2;
    else             first_low = 2'd3;
  endfunction

  // Row-major key map: r0 1 2 3 A / r1 4 5 6 B / r2 7 8 9 C / r3 E 0 F D.
  function automatic logic [3:0] key_code(input logic [1:0] r, input logic [1:0] c);
    case ({r, c})
      4'h0: key_code = 4'h1;
      4'h1: key_code = 4'h2;
      4'h2: key_code = 4'h3;
      4'h3: key_code = 4'hA;
      4'h4: key_code = 4'h4;
      4'h5: key_code = 4'h5;
      4'h6: key_code = 4'h6;
      4'h7: key_code = 4'hB;
      4'h8: key_code = 4'h7;
      4'h9: key_code = 4'h8;
      4'hA: key_code = 4'h9;
      4'hB: key_code = 4'hC;
      4'hC: key_code = 4'hE;
      4'hD: key_code = 4'h0;
      4'hE: key_code = 4'hF;
      default: key_code = 4'hD;
    endcase
  endfunction

  assign tick    = (presc == PW'(SCAN_DIV - 1));
  assign db_done = (dbc == DW'(DEBOUNCE_TICKS - 1));

  // Synchronizer, prescaler and scan/debounce FSM with registered outputs.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      row_m     <= 4'hF;
      row_s     <= 4'hF;
      presc     <= '0;
      state     <= SCAN;
      col_idx   <= 2'd0;
      col       <= 4'b1110;
      row_idx   <= 2'd0;
      dbc       <= '0;
      key       <= 4'h0;
      key_valid <= 1'b0;
      key_held  <= 1'b0;
`ifdef KEYPAD_HISTORY_EN
      digit_new <= 4'h0;
      digit_old <= 4'h0;
`endif
    end else begin
      row_m     <= row;
      row_s     <= row_m;
      key_valid <= 1'b0;
      presc     <= tick ? '0 : presc + PW'(1);

      if (tick) begin
        case (state)
          SCAN: begin
            if (row_s == 4'hF) begin
              col_idx <= col_idx + 2'd1;
              col     <= col_drive(col_idx + 2'd1);
            end else begin
              row_idx <= first_low(row_s);
              dbc     <= '0;
              state   <= PRESS_DB;
            end
          end
          PRESS_DB: begin
            if (!row_s[row_idx]) begin
              if (db_done) begin
                key       <= key_code(row_idx, col_idx);
                key_valid <= 1'b1;
                key_held  <= 1'b1;
`ifdef KEYPAD_HISTORY_EN
                digit_old <= digit_new;
                digit_new <= key_code(row_idx, col_idx);
`endif
                state     <= HELD;
              end else begin
                dbc <= dbc + DW'(1);
              end
            end else begin
              // Bounce: abandon this column and resume scanning after it.
              col_idx <= col_idx + 2'd1;
              col     <= col_drive(col_idx + 2'd1);
              state   <= SCAN;
            end
          end
          HELD: begin
            if (row_s[row_idx]) begin
              dbc   <= '0;
              state <= REL_DB;
            end
          end
          REL_DB: begin
            if (row_s[row_idx]) begin
              if (db_done) begin
                key_held <= 1'b0;
                col_idx  <= col_idx + 2'd1;
                col      <= col_drive(col_idx + 2'd1);
                state    <= SCAN;
              end else begin
                dbc <= dbc + DW'(1);
              end
            end else begin
              // Re-closure restarts the release count without a new press.
              dbc <= '0;
            end
          end
          default: state <= SCAN;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_keypad_scanner.sv
// Testbench for keypad_scanner: a keypad matrix model drives the rows from
// the scanned columns; a monitor checks every key_valid pulse against a
// queue of expected key codes pushed by the stimulus.
module tb_keypad_scanner;

  localparam int unsigned SCAN_DIV       = 4;
  localparam int unsigned DEBOUNCE_TICKS = 3;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [3:0] row;
  logic [3:0] col;
  logic [3:0] key;
  logic       key_valid;
  logic       key_held;
`ifdef KEYPAD_HISTORY_EN
  logic [3:0] digit_new;
  logic [3:0] digit_old;
`endif

  // pressed[r][c] = 1 closes the switch between row r and column c.
  logic [3:0] pressed [4];

  int         n_cmp = 0;
  int         n_err = 0;
  logic [3:0] exp_q [$];

  always #5 clk = ~clk;

  keypad_scanner #(
    .SCAN_DIV      (SCAN_DIV),
    .DEBOUNCE_TICKS(DEBOUNCE_TICKS)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .row      (row),
    .col      (col),
    .key      (key),
    .key_valid(key_valid),
    .key_held (key_held)
`ifdef KEYPAD_HISTORY_EN
    ,
    .digit_new(digit_new),
    .digit_old(digit_old)
`endif
  );

  // Matrix model: a row is pulled low by any closed key in a driven column.
  always_comb begin
    for (int r = 0; r < 4; r++) begin
      row[r] = ~|(pressed[r] & ~col);
    end
  end

  task automatic chk(input string name, input logic [3:0] act, input logic [3:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic release_all();
    for (int r = 0; r < 4; r++) pressed[r] = 4'b0000;
  endtask

  task automatic press(input logic [1:0] r, input logic [1:0] c);
    pressed[r][c] = 1'b1;
  endtask

  task automatic wait_held(input logic v, input int max, input string name);
    int i = 0;
    while (key_held !== v && i < max) begin
      @(negedge clk);
      i++;
    end
    chk(name, {3'b000, key_held}, {3'b000, v});
  endtask

  task automatic wait_col(input logic [3:0] c, input logic eq, input int max, input string name);
    int i = 0;
    while (((col === c) != eq) && i < max) begin
      @(negedge clk);
      i++;
    end
    chk(name, {3'b000, (col === c)}, {3'b000, eq});
  endtask

  // Scoreboard monitor: every pulse must match the oldest expected key.
  always @(negedge clk) begin
    if (key_valid === 1'b1) begin
      logic [3:0] e;
      n_cmp++;
      if (exp_q.size() == 0) begin
        n_err++;
        $display("FAIL unexpected_pulse: key %h with no press expected (t=%0t)", key, $time);
      end else begin
        e = exp_q.pop_front();
        if (key !== e || key_held !== 1'b1) begin
          n_err++;
          $display("FAIL pulse_key: got key %h held %b expected key %h held 1 (t=%0t)",
                   key, key_held, e, $time);
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    release_all();
    reset = 1'b1;
    repeat (3) @(negedge clk);
    chk("rst_col", col, 4'b1110);
    chk("rst_key", key, 4'h0);
    chk("rst_valid", {3'b000, key_valid}, 4'h0);
    chk("rst_held", {3'b000, key_held}, 4'h0);
    reset = 1'b0;

    // Clean press of '6' (row1/col2), held for 20 ticks.
    exp_q.push_back(4'h6);
    press(2'd1, 2'd2);
    wait_held(1'b1, 200, "press6_held");
    chk("press6_key", key, 4'h6);
    for (int t = 0; t < 20; t++) begin
      repeat (SCAN_DIV) @(negedge clk);
      chk("press6_col_stuck", col, 4'b1011);
    end

    // Release bounce: release, re-close briefly, release for good.
    release_all();
    repeat (8) @(negedge clk);
    chk("relb_held_mid", {3'b000, key_held}, 4'h1);
    press(2'd1, 2'd2);
    repeat (6) @(negedge clk);
    release_all();
    repeat (6) @(negedge clk);
    chk("relb_held_after_reclose", {3'b000, key_held}, 4'h1);
    wait_held(1'b0, 60, "relb_held_fall");
    chk("relb_key_kept", key, 4'h6);

    // Press bounce: row1 low for a single tick while col2 is driven.
    wait_col(4'b1011, 1'b0, 40, "pb_leave_col2");
    wait_col(4'b1011, 1'b1, 40, "pb_reach_col2");
    press(2'd1, 2'd2);
    repeat (4) @(negedge clk);
    release_all();
    wait_col(4'b1011, 1'b0, 40, "pb_col_moved");
    chk("pb_next_col", col, 4'b0111);
    chk("pb_no_held", {3'b000, key_held}, 4'h0);

    // Same-column double press resolves to the lowest row ('2' over '8').
    exp_q.push_back(4'h2);
    press(2'd0, 2'd1);
    press(2'd2, 2'd1);
    wait_held(1'b1, 200, "dbl_held");
    chk("dbl_key", key, 4'h2);
    press(2'd0, 2'd3);
    press(2'd1, 2'd3);
    for (int t = 0; t < 10; t++) begin
      repeat (SCAN_DIV) @(negedge clk);
      chk("dbl_col_stuck", col, 4'b1101);
    end
    chk("dbl_key_kept", key, 4'h2);
    release_all();
    wait_held(1'b0, 80, "dbl_release");

    // History: press '3', release, press 'E'.
    exp_q.push_back(4'h3);
    press(2'd0, 2'd2);
    wait_held(1'b1, 200, "hist3_held");
    release_all();
    wait_held(1'b0, 80, "hist3_release");
    exp_q.push_back(4'hE);
    press(2'd3, 2'd0);
    wait_held(1'b1, 200, "histE_held");
    chk("histE_key", key, 4'hE);
`ifdef KEYPAD_HISTORY_EN
    chk("hist_old", digit_old, 4'h3);
    chk("hist_new", digit_new, 4'hE);
`endif

    // Reset asserted while a key is held takes effect immediately.
    repeat (2) @(negedge clk);
    reset = 1'b1;
    #1;
    chk("rstheld_col", col, 4'b1110);
    chk("rstheld_key", key, 4'h0);
    chk("rstheld_held", {3'b000, key_held}, 4'h0);
    chk("rstheld_valid", {3'b000, key_valid}, 4'h0);
`ifdef KEYPAD_HISTORY_EN
    chk("rstheld_new", digit_new, 4'h0);
    chk("rstheld_old", digit_old, 4'h0);
`endif
    release_all();
    repeat (3) @(negedge clk);
    reset = 1'b0;
    repeat (40) @(negedge clk);
    chk("post_rst_held", {3'b000, key_held}, 4'h0);

    chk("queue_drained", 4'(exp_q.size()), 4'h0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/keypad_scanner.md
# keypad_scanner

Scans a 4x4 matrix keypad by driving one column low at a time and sampling the four row lines. Debounces press and release and reports each press as a one-cycle `key_valid` pulse with a 4-bit hex code. It is the input-side counterpart of the time-multiplexed dual seven-segment display path: its key codes (optionally a two-digit history) feed the display digit selects.

## Interface
- `SCAN_DIV`, 256: clk cycles per scan tick (column dwell); must be >= 4.
- `DEBOUNCE_TICKS`, 10: consecutive stable ticks required to accept a press or a release; must be >= 1.

- `clk`, in, 1: system clock; one clock domain.
- `reset`, in, 1: asynchronous, active-high reset.
- `row`, in, 4: keypad rows, active-low (pulled up externally), asynchronous to `clk`.
- `col`, out, 4: keypad columns, active-low, exactly one bit low at all times.
- `key`, out, 4: hex code of the last accepted key.
- `key_valid`, out, 1: one-cycle pulse when a press is accepted.
- `key_held`, out, 1: high from acceptance until the release is accepted.
- `digit_new`, out, 4: most recent key. Present only with `KEYPAD_HISTORY_EN`.
- `digit_old`, out, 4: previous key. Present only with `KEYPAD_HISTORY_EN`.

## Operation
- Reset values: `col`=4'b1110, `key`=0, `key_valid`=0, `key_held`=0, FSM=SCAN, column index 0, prescaler 0, debounce count 0, digits 0.
- `row` passes through a 2-flop synchronizer. All decisions use the synchronized `row_s`.
- Prescaler counts 0..SCAN_DIV-1 and asserts `tick` for one cycle at SCAN_DIV-1, then wraps.
- Key map, row r / col c, row-major: r0: 1 2 3 A; r1: 4 5 6 B; r2: 7 8 9 C; r3: E 0 F D.
- FSM states and transitions:
  - SCAN:
    - On `tick` with `row_s`==4'hF, advance the column index (3 wraps to 0) and drive the new column.
    - On `tick` with any row low, latch the lowest-numbered low row and keep the column. Clear the count and go to PRESS_DB.
  - PRESS_DB:
    - On `tick` with the latched row low, increment the count.
    - When the count reaches DEBOUNCE_TICKS, register `key`, pulse `key_valid`, set `key_held`, and go to HELD.
    - On `tick` with the latched row high, return to SCAN and advance to the next column. No pulse.
  - HELD: column stays driven. On `tick` with the latched row high, clear the count and go to REL_DB.
  - REL_DB:
    - On `tick` with the latched row high, increment the count.
    - When the count reaches DEBOUNCE_TICKS, clear `key_held`, advance the column, and go to SCAN.
    - On `tick` with the latched row low, clear the count and stay in REL_DB. No new pulse.
- Multiple keys:
  - Keys in other columns are invisible while a column is held.
  - Other rows in the held column are ignored; only the latched row is tracked.
  - Simultaneous presses in one column resolve to the lowest row.
- `key` holds its value until the next accepted press. It is never cleared by release.
- Reset asserted in any state forces the reset values immediately. No `key_valid` is emitted.

## Timing
- Synchronizer latency is 2 clk cycles. Columns change only on the cycle after `tick`, so rows settle for at least SCAN_DIV-3 cycles before the next sample.
- `key_valid`, `key`, and `key_held` are registered and change together, one cycle after the accepting `tick`.
- `key_valid` is high for exactly one clk cycle per press.
- Press-to-pulse latency is at most (4 + DEBOUNCE_TICKS + 1)·SCAN_DIV + 3 cycles.
- Release-to-`key_held` low is DEBOUNCE_TICKS·SCAN_DIV cycles plus up to SCAN_DIV + 3.

## Configuration
- `KEYPAD_HISTORY_EN` defined:
  - `digit_new` and `digit_old` ports and registers exist.
  - In the `key_valid` cycle: `digit_old` <= `digit_new`, `digit_new` <= new key code.
  - Both reset to 0.
- Not defined: the ports and registers are absent. All other behaviour is identical.

## Test plan
Bench parameters: SCAN_DIV=4, DEBOUNCE_TICKS=3.
- Reset mid-HELD: assert `reset` while `key_held`=1 -> same cycle `col`=4'b1110, `key`=0, `key_held`=0, no `key_valid`.
- Clean press row1/col2 held for 20 ticks -> exactly one `key_valid` with `key`=4'h6, `key_held`=1, `col` stuck at 4'b1011 until release.
- Press bounce: row1 low for 1 tick at col2, then high -> no `key_valid`; `col` resumes at 4'b0111.
- Release bounce: release '6', re-close for 1 tick, then release -> no second `key_valid`; `key_held` falls 3 clean ticks after the final release; `key` stays 4'h6.
- Same-column double press: rows 0 and 2 both low at col1 -> single pulse with `key`=4'h2. With the key held, pressing col3 keys -> no pulse.
- History (macro on): press '3', release, press 'E' -> after the second pulse `digit_old`=4'h3, `digit_new`=4'hE.
